// File: rtl/wb_matmul_engine_if.sv
// Wishbone slave bundle for wb_matmul_engine; signal names follow the engine's port perspective.
interface wb_matmul_engine_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/wb_matmul_engine.sv
// Wishbone-mapped NxN matrix multiplier C = A*B: one MAC per cycle, N*N*(N+1) cycles per run.
// Every access is acked one cycle after request; busy-time A/B/start writes are acked and dropped.
module wb_matmul_engine #(
  parameter int          N         = 2,
  parameter int          DW        = 8,
  parameter int          SIGNED    = 0,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  wb_matmul_engine_if.slave wbs,
  output logic              busy_o,
  output logic              irq_o
);
  localparam int ACCW = 2*DW + $clog2(N);
  localparam int IW   = $clog2(N);
  localparam logic [IW-1:0] IMAX = IW'(N-1);
  localparam logic [IW-1:0] IONE = IW'(1);

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_STORE, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   i_q, i_d, j_q, j_d, k_q, k_d;
  logic [ACCW-1:0] acc_q, acc_d, prod;
  logic            done_q, done_d;
  logic            c_we, done_set;

  logic [DW-1:0]   a_q [N][N];
  logic [DW-1:0]   b_q [N][N];
  logic [ACCW-1:0] c_q [N][N];

  logic            ack_q, irq_en_q, start_q;
  logic [31:0]     dat_q, rdata;

  logic            access, base_hit, wr, busy, idx_ok;
  logic            a_wr, b_wr, ctrl_wr, stat_wr, start_ok, done_clr;
  logic [3:0]      region;
  logic [5:0]      idx;
  logic            unused_ok;

  function automatic logic [ACCW-1:0] ext(input logic [DW-1:0] v);
    if (SIGNED != 0) return {{(ACCW-DW){v[DW-1]}}, v};
    else             return {{(ACCW-DW){1'b0}}, v};
  endfunction

  function automatic logic [31:0] cext(input logic [ACCW-1:0] v);
    if (SIGNED != 0) return {{(32-ACCW){v[ACCW-1]}}, v};
    else             return {{(32-ACCW){1'b0}}, v};
  endfunction

  // Word index within a 256-byte region; byte lanes are ignored.
  assign access   = wbs.wbs_cyc_i & wbs.wbs_stb_i & ~ack_q;
  assign base_hit = (wbs.wbs_adr_i[31:12] == BASE_ADDR[31:12]);
  assign region   = wbs.wbs_adr_i[11:8];
  assign idx      = wbs.wbs_adr_i[7:2];
  assign idx_ok   = ({1'b0, idx} < 7'(N*N));
  assign wr       = access & wbs.wbs_we_i & base_hit;
  assign busy     = (state_q == S_MAC) || (state_q == S_STORE);

  assign a_wr     = wr & (region == 4'h0) & idx_ok & ~busy;
  assign b_wr     = wr & (region == 4'h1) & idx_ok & ~busy;
  assign ctrl_wr  = wr & (region == 4'h3) & (idx == 6'd0);
  assign stat_wr  = wr & (region == 4'h3) & (idx == 6'd1);
  assign start_ok = ctrl_wr & wbs.wbs_dat_i[0] & ((state_q == S_IDLE) || (state_q == S_DONE));
  assign done_clr = stat_wr & wbs.wbs_dat_i[1];

  assign unused_ok = ^{wbs.wbs_sel_i, wbs.wbs_adr_i[1:0], wbs.wbs_dat_i[31:DW]};

  always_comb begin
    rdata = '0;
    if (base_hit) begin
      case (region)
        4'h0: begin
          for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
              if (idx == 6'(r*N + c)) rdata = 32'(a_q[r][c]);
        end
        4'h1: begin
          for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
              if (idx == 6'(r*N + c)) rdata = 32'(b_q[r][c]);
        end
        4'h2: begin
          for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
              if (idx == 6'(r*N + c)) rdata = cext(c_q[r][c]);
        end
        4'h3: begin
          if (idx == 6'd0)      rdata = {30'd0, irq_en_q, 1'b0};
          else if (idx == 6'd1) rdata = {30'd0, done_q, busy};
        end
        default: rdata = '0;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      ack_q    <= 1'b0;
      dat_q    <= '0;
      irq_en_q <= 1'b0;
      start_q  <= 1'b0;
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++) begin
          a_q[r][c] <= '0;
          b_q[r][c] <= '0;
        end
    end else begin
      ack_q   <= access;
      dat_q   <= access ? rdata : '0;
      start_q <= start_ok;
      if (ctrl_wr) irq_en_q <= wbs.wbs_dat_i[1];
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++) begin
          if (a_wr && idx == 6'(r*N + c)) a_q[r][c] <= wbs.wbs_dat_i[DW-1:0];
          if (b_wr && idx == 6'(r*N + c)) b_q[r][c] <= wbs.wbs_dat_i[DW-1:0];
        end
    end
  end

  // Operands are extended to ACCW first, so the truncated product is exact for both signednesses.
  assign prod = ext(a_q[i_q][k_q]) * ext(b_q[k_q][j_q]);

  always_comb begin
    state_d  = state_q;
    i_d      = i_q;
    j_d      = j_q;
    k_d      = k_q;
    acc_d    = acc_q;
    c_we     = 1'b0;
    done_set = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_q) begin
          state_d = S_MAC;
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
          acc_d   = '0;
        end
      end
      S_MAC: begin
        acc_d = acc_q + prod;
        if (k_q == IMAX) begin
          k_d     = '0;
          state_d = S_STORE;
        end else begin
          k_d = k_q + IONE;
        end
      end
      S_STORE: begin
        c_we  = 1'b1;
        acc_d = '0;
        if (j_q == IMAX) begin
          j_d = '0;
          if (i_q == IMAX) begin
            state_d  = S_DONE;
            done_set = 1'b1;
          end else begin
            i_d     = i_q + IONE;
            state_d = S_MAC;
          end
        end else begin
          j_d     = j_q + IONE;
          state_d = S_MAC;
        end
      end
      S_DONE: begin
        state_d  = S_IDLE;
        done_set = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    // A clear racing with completion must not hide the completion.
    done_d = done_q;
    if (done_clr || start_q) done_d = 1'b0;
    if (done_set)            done_d = 1'b1;
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= S_IDLE;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      acc_q   <= '0;
      done_q  <= 1'b0;
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++)
          c_q[r][c] <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
      done_q  <= done_d;
      if (c_we) c_q[i_q][j_q] <= acc_q;
    end
  end

  assign wbs.wbs_ack_o = ack_q;
  assign wbs.wbs_dat_o = dat_q;
  assign busy_o        = busy;
  assign irq_o         = done_q & irq_en_q;
endmodule

// File: tb/tb_wb_matmul_engine.sv
// Bench for wb_matmul_engine: an unsigned and a signed 2x2 instance share one bus driver selected by tgt.
module tb_wb_matmul_engine;
  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam int N   = 2;
  localparam int LAT = N*N*(N+1);

  typedef int          mat_t [N*N];
  typedef logic [31:0] res_t [N*N];
  typedef struct packed {
    logic        we;
    logic        chk;
    logic [31:0] adr;
    logic [31:0] wdat;
    logic [31:0] exp;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        cyc_r, stb_r, we_r;
  logic [31:0] adr_r, wd_r;
  int          tgt;
  int          checks = 0;
  int          errors = 0;
  int          last_lat;
  int          ncyc = 0;
  int          last_rise = 0;
  int          last_fall = 0;
  logic        busy_prev = 1'b0;

  wb_matmul_engine_if bus0 ();
  wb_matmul_engine_if bus1 ();

  assign bus0.wbs_cyc_i = cyc_r & (tgt == 0);
  assign bus0.wbs_stb_i = stb_r;
  assign bus0.wbs_we_i  = we_r;
  assign bus0.wbs_sel_i = 4'hF;
  assign bus0.wbs_adr_i = adr_r;
  assign bus0.wbs_dat_i = wd_r;
  assign bus1.wbs_cyc_i = cyc_r & (tgt == 1);
  assign bus1.wbs_stb_i = stb_r;
  assign bus1.wbs_we_i  = we_r;
  assign bus1.wbs_sel_i = 4'hF;
  assign bus1.wbs_adr_i = adr_r;
  assign bus1.wbs_dat_i = wd_r;

  logic busy0, irq0, busy1, irq1;

  wb_matmul_engine #(.N(N), .DW(8), .SIGNED(0), .BASE_ADDR(BASE)) dut0 (
    .wb_clk_i(clk), .wb_rst_i(rst), .wbs(bus0.slave), .busy_o(busy0), .irq_o(irq0)
  );
  wb_matmul_engine #(.N(N), .DW(8), .SIGNED(1), .BASE_ADDR(BASE)) dut1 (
    .wb_clk_i(clk), .wb_rst_i(rst), .wbs(bus1.slave), .busy_o(busy1), .irq_o(irq1)
  );

  logic        ack_s, busy_s, irq_s;
  logic [31:0] rdat_s;
  assign ack_s  = (tgt == 0) ? bus0.wbs_ack_o : bus1.wbs_ack_o;
  assign rdat_s = (tgt == 0) ? bus0.wbs_dat_o : bus1.wbs_dat_o;
  assign busy_s = (tgt == 0) ? busy0 : busy1;
  assign irq_s  = (tgt == 0) ? irq0 : irq1;

  always @(posedge clk) ncyc <= ncyc + 1;

  always @(negedge clk) begin
    if (busy_s && !busy_prev) last_rise <= ncyc;
    if (!busy_s && busy_prev) last_fall <= ncyc;
    busy_prev <= busy_s;
  end

  function automatic logic [31:0] a_adr(input int e); return BASE + 32'(4*e); endfunction
  function automatic logic [31:0] b_adr(input int e); return BASE + 32'h100 + 32'(4*e); endfunction
  function automatic logic [31:0] c_adr(input int e); return BASE + 32'h200 + 32'(4*e); endfunction
  localparam logic [31:0] CTRL = BASE + 32'h300;
  localparam logic [31:0] STAT = BASE + 32'h304;

  // Reference: element value as the spec's signedness sees it, then plain integer dot product.
  function automatic int sx(input int v, input int sgn);
    int m;
    m = v & 255;
    if (sgn != 0 && m >= 128) m = m - 256;
    return m;
  endfunction

  function automatic logic [31:0] model_elem(input int sgn, input mat_t a, input mat_t b,
                                             input int r, input int c);
    int s;
    s = 0;
    for (int k = 0; k < N; k++) s += sx(a[r*N+k], sgn) * sx(b[k*N+c], sgn);
    return s;
  endfunction

  function automatic vec_t mkv(input logic we, input logic chk, input logic [31:0] adr,
                               input logic [31:0] wd, input logic [31:0] exp);
    vec_t v;
    v.we = we; v.chk = chk; v.adr = adr; v.wdat = wd; v.exp = exp;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic bus_xfer(input logic we, input logic [31:0] adr, input logic [31:0] wd,
                          output logic [31:0] rd);
    @(negedge clk);
    cyc_r = 1'b1; stb_r = 1'b1; we_r = we; adr_r = adr; wd_r = wd;
    rd = '0;
    last_lat = 0;
    for (int t = 1; t <= 8; t++) begin
      @(negedge clk);
      if (ack_s) begin
        rd = rdat_s;
        last_lat = t;
        break;
      end
    end
    cyc_r = 1'b0; stb_r = 1'b0; we_r = 1'b0;
    if (last_lat == 0) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout adr=0x%08h: no ack in 8 cycles, expected ack after 1", adr);
    end
  endtask

  task automatic wr(input logic [31:0] adr, input logic [31:0] d);
    logic [31:0] dummy;
    bus_xfer(1'b1, adr, d, dummy);
  endtask

  task automatic rd_chk(input string name, input logic [31:0] adr, input logic [31:0] exp);
    logic [31:0] v;
    bus_xfer(1'b0, adr, '0, v);
    check(name, v, exp);
  endtask

  task automatic load(input mat_t a, input mat_t b);
    for (int e = 0; e < N*N; e++) begin
      wr(a_adr(e), a[e]);
      wr(b_adr(e), b[e]);
    end
  endtask

  task automatic start_comp(input logic ien, output int c0);
    wr(CTRL, {30'd0, ien, 1'b1});
    c0 = ncyc;
  endtask

  task automatic wait_done(input string tag, input int c0);
    for (int t = 0; t < 400 && !(last_fall > c0); t++) @(posedge clk);
    @(negedge clk);
    check({tag, "_busy_rise"}, last_rise - c0, 1);
    check({tag, "_busy_len"}, last_fall - last_rise, LAT);
  endtask

  task automatic read_c(input string tag, input res_t exp);
    for (int e = 0; e < N*N; e++) rd_chk($sformatf("%s_C%0d", tag, e), c_adr(e), exp[e]);
  endtask

  task automatic run_mat(input int t, input mat_t a, input mat_t b, input res_t exp,
                         input string tag);
    int c0;
    tgt = t;
    load(a, b);
    start_comp(1'b0, c0);
    wait_done(tag, c0);
    read_c(tag, exp);
    rd_chk({tag, "_status"}, STAT, 32'h2);
  endtask

  vec_t        vt [$];
  mat_t        ma, mb, mid;
  res_t        me;
  logic [31:0] rv;
  int          c0;

  initial begin
    rst = 1'b1; cyc_r = 1'b0; stb_r = 1'b0; we_r = 1'b0; adr_r = '0; wd_r = '0; tgt = 0;
    repeat (3) @(negedge clk);
    check("rst_busy0", busy0, 0);
    check("rst_irq0", irq0, 0);
    check("rst_ack0", bus0.wbs_ack_o, 0);
    check("rst_dat0", bus0.wbs_dat_o, 0);
    rst = 1'b0;

    vt.push_back(mkv(0, 1, a_adr(0),  0,             0));
    vt.push_back(mkv(0, 1, STAT,      0,             0));
    vt.push_back(mkv(0, 1, CTRL,      0,             0));
    vt.push_back(mkv(1, 0, a_adr(0),  32'h1FF,       0));
    vt.push_back(mkv(0, 1, a_adr(0),  0,             32'hFF));
    vt.push_back(mkv(1, 0, a_adr(3),  32'hABCD_EF12, 0));
    vt.push_back(mkv(0, 1, a_adr(3),  0,             32'h12));
    vt.push_back(mkv(1, 0, b_adr(1),  32'h7,         0));
    vt.push_back(mkv(0, 1, b_adr(1),  0,             32'h7));
    vt.push_back(mkv(1, 0, a_adr(4),  32'h5,         0));
    vt.push_back(mkv(0, 1, a_adr(4),  0,             0));
    vt.push_back(mkv(1, 0, c_adr(0),  32'h55,        0));
    vt.push_back(mkv(0, 1, c_adr(0),  0,             0));
    vt.push_back(mkv(0, 1, BASE + 32'h308, 0,        0));
    vt.push_back(mkv(0, 1, BASE + 32'h400, 0,        0));
    vt.push_back(mkv(1, 0, CTRL,      32'h2,         0));
    vt.push_back(mkv(0, 1, CTRL,      0,             32'h2));
    vt.push_back(mkv(1, 0, CTRL,      32'h0,         0));
    vt.push_back(mkv(0, 1, CTRL,      0,             0));
    vt.push_back(mkv(1, 0, BASE + 32'h1000, 32'h33,  0));
    vt.push_back(mkv(0, 1, BASE + 32'h1000, 0,       0));
    vt.push_back(mkv(0, 1, a_adr(0),  0,             32'hFF));

    for (int i = 0; i < vt.size(); i++) begin
      bus_xfer(vt[i].we, vt[i].adr, vt[i].wdat, rv);
      check($sformatf("vec%0d_ack_lat", i), last_lat, 1);
      if (vt[i].chk) check($sformatf("vec%0d_rdata", i), rv, vt[i].exp);
    end

    // Ack is a one-cycle pulse and read data returns to zero behind it.
    @(negedge clk);
    check("ack_pulse", ack_s, 0);
    check("dat_idle", rdat_s, 0);

    ma = '{1, 2, 3, 4}; mb = '{5, 6, 7, 8}; me = '{19, 22, 43, 50};
    run_mat(0, ma, mb, me, "basic");
    check("irq_masked", irq_s, 0);

    ma = '{255, 255, 255, 255}; mb = '{255, 255, 255, 255};
    me = '{32'h1FC02, 32'h1FC02, 32'h1FC02, 32'h1FC02};
    run_mat(0, ma, mb, me, "max");

    ma = '{-1, 2, 3, -4}; mb = '{1, 0, 0, 1};
    me = '{32'hFFFF_FFFF, 32'h2, 32'h3, 32'hFFFF_FFFC};
    run_mat(1, ma, mb, me, "signed");
    rd_chk("signed_A0_zext", a_adr(0), 32'hFF);

    // Start and A write during busy are dropped; timing stays anchored to the first start.
    tgt = 0;
    ma = '{1, 2, 3, 4}; mb = '{5, 6, 7, 8}; me = '{19, 22, 43, 50};
    load(ma, mb);
    start_comp(1'b0, c0);
    wr(a_adr(0), 32'h9);
    wr(CTRL, 32'h1);
    rd_chk("busy_status", STAT, 32'h1);
    wait_done("restart", c0);
    read_c("restart", me);
    rd_chk("restart_A0", a_adr(0), 32'h1);

    // Done clear presented on the edge that enters DONE.
    start_comp(1'b0, c0);
    for (int t = 0; t < 50 && ncyc < c0 + LAT - 1; t++) @(negedge clk);
    wr(STAT, 32'h2);
    rd_chk("race_status", STAT, 32'h2);
    wait_done("race", c0);

    wr(CTRL, 32'h2);
    start_comp(1'b1, c0);
    wait_done("irq", c0);
    check("irq_set", irq_s, 1);
    wr(STAT, 32'h2);
    check("irq_clr", irq_s, 0);
    rd_chk("irq_status", STAT, 32'h0);
    wr(CTRL, 32'h0);

    // Reset lands in the middle of a computation.
    start_comp(1'b1, c0);
    for (int t = 0; t < 50 && ncyc < c0 + 5; t++) @(negedge clk);
    check("midrst_busy_before", busy_s, 1);
    rst = 1'b1;
    #1;
    check("midrst_busy", busy_s, 0);
    check("midrst_irq", irq_s, 0);
    check("midrst_ack", ack_s, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int e = 0; e < N*N; e++) begin
      rd_chk($sformatf("midrst_A%0d", e), a_adr(e), 0);
      rd_chk($sformatf("midrst_B%0d", e), b_adr(e), 0);
      rd_chk($sformatf("midrst_C%0d", e), c_adr(e), 0);
    end
    rd_chk("midrst_ctrl", CTRL, 0);
    rd_chk("midrst_status", STAT, 0);
    run_mat(0, ma, mb, me, "postrst");

    for (int it = 0; it < 8; it++) begin
      for (int e = 0; e < N*N; e++) begin
        ma[e] = int'($urandom_range(0, 255));
        mb[e] = int'($urandom_range(0, 255));
      end
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++)
          me[r*N+c] = model_elem(it % 2, ma, mb, r, c);
      run_mat(it % 2, ma, mb, me, $sformatf("rand%0d", it));
    end

    mid = '{0, 0, 0, 0};
    tgt = 1;
    load(mid, mid);
    rd_chk("signed_clear_A3", a_adr(3), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/wb_matmul_engine.md
WB_MATMUL_ENGINE -- requirements
Module: wb_matmul_engine

Interface
REQ-001 The block SHALL have parameter N, default 2, meaning square matrix dimension, legal range 2..8.
REQ-002 The block SHALL have parameter DW, default 8, meaning element width in bits, legal range 4..12.
REQ-003 The block SHALL have parameter SIGNED, default 0: 0 means unsigned operands, 1 means two's-complement operands.
REQ-004 The block SHALL have parameter BASE_ADDR, default 32'h3000_0000, meaning the Wishbone base; adr[31:12] is compared to BASE_ADDR[31:12].
REQ-005 The block SHALL define derived ACCW = 2*DW + clog2(N), which is at most 32 for all legal parameters.
REQ-006 The block SHALL have the following ports (name, direction, width, meaning):
- wb_clk_i  in  1  single clock, rising edge.
- wb_rst_i  in  1  reset, asynchronous, active-high.
- wbs_cyc_i  in  1  bus cycle.
- wbs_stb_i  in  1  strobe.
- wbs_we_i  in  1  write enable.
- wbs_sel_i  in  4  byte selects; ignored, all accesses are whole-word.
- wbs_adr_i  in  32  byte address.
- wbs_dat_i  in  32  write data.
- wbs_ack_o  out  1  acknowledge.
- wbs_dat_o  out  32  read data.
- busy_o  out  1  computation in progress.
- irq_o  out  1  done interrupt, level.

Function
REQ-007 Register map offsets (adr[11:0]) SHALL be:
- A[r][c] at 0x000 + 4*(r*N+c), read/write.
- B[r][c] at 0x100 + 4*(r*N+c), read/write.
- C[r][c] at 0x200 + 4*(r*N+c), read-only.
- CTRL at 0x300: bit0 start (write-1 pulse), bit1 irq_en (read/write).
- STATUS at 0x304: bit0 busy, bit1 done (write-1-to-clear).
REQ-008 A and B elements SHALL store wbs_dat_i[DW-1:0] on write and SHALL read back zero-extended to 32 bits.
REQ-009 C elements SHALL read back as ACCW bits, zero-extended if SIGNED=0 and sign-extended if SIGNED=1.
REQ-010 Reads of unmapped offsets, of element indices >= N*N, or with a non-matching base SHALL return 0; writes to them SHALL have no effect; all such accesses SHALL still be acked.
REQ-011 wbs_ack_o SHALL assert exactly one cycle after a cycle in which cyc&stb=1 and ack=0, and SHALL be a single-cycle pulse.
REQ-012 wbs_dat_o SHALL be valid in the ack cycle and 0 otherwise.
REQ-013 A write of CTRL bit0=1 while in IDLE or DONE SHALL start a computation in the cycle after the ack, SHALL clear done, and SHALL set busy.
REQ-014 The FSM SHALL have states IDLE, MAC, STORE, DONE.
REQ-015 In MAC, the block SHALL perform one multiply-accumulate per cycle: acc += A[i][k]*B[k][j], k = 0..N-1; acc SHALL be cleared on entry to MAC for each (i,j).
REQ-016 After k=N-1 the FSM SHALL go to STORE, which writes acc to C[i][j], then advances j (and i on wrap) and returns to MAC; after C[N-1][N-1] it SHALL go to DONE.
REQ-017 Total latency from the first MAC cycle to entry of DONE SHALL be N*N*(N+1) cycles (12 for N=2).
REQ-018 DONE SHALL set done=1 and busy=0 and return to IDLE in the next cycle; done SHALL remain sticky until cleared.
REQ-019 Products and accumulation SHALL be computed in ACCW bits with no overflow possible; signedness SHALL follow SIGNED.
REQ-020 While busy, writes to A, B and CTRL.start SHALL be acked and ignored; writes to irq_en and reads of all registers (including partially written C) SHALL proceed normally.
REQ-021 Done clear (STATUS bit1 write) in the same cycle as DONE entry SHALL lose to the set (done=1).
REQ-022 busy_o SHALL be 1 in states MAC and STORE; irq_o SHALL equal done & irq_en.

Reset
REQ-023 wb_rst_i=1 SHALL immediately force the FSM to IDLE and set all A, B, C, acc, indices, irq_en, done, busy_o, irq_o, wbs_ack_o and wbs_dat_o to 0, including mid-computation.
REQ-024 After reset release, the first bus access SHALL be handled normally with no dummy cycles.

Verification
REQ-025 N=2, DW=8, unsigned, A=[[1,2],[3,4]], B=[[5,6],[7,8]], start -> busy for 12 cycles, then C=[[19,22],[43,50]] and STATUS=0x2.
REQ-026 N=2, DW=8, all elements 255 -> every C element = 130050 (0x1FC02); no truncation.
REQ-027 SIGNED=1, DW=8, A=[[-1,2],[3,-4]], B=identity -> C reads 0xFFFFFFFF, 2, 3, 0xFFFFFFFC.
REQ-028 Start and an A write issued mid-computation -> both acked, result unchanged, and latency still 12 cycles from the original start.
REQ-029 irq_en=1, completion -> irq_o=1; STATUS write 0x2 -> irq_o=0 the next cycle.
REQ-030 Assert wb_rst_i at cycle 5 of a computation -> busy_o=0 and all A, B, C read 0; a fresh load and start then gives the correct result.
